grant_ack_source: RTL and testbench

Generates TileLink E-channel GrantAck messages for the inclusive cache's outer (D-channel) sink. It consumes the per-message response strobe that the D-channel sink raises toward the MSHRs. For every Grant or GrantData message, it queues the message's sink id and issues exactly one GrantAck on the outer E channel. It also reports queue room back upstream so the D-channel sink can be throttled before acks are lost.

---
 rtl/grant_ack_pkg.sv | 17 +
 rtl/grant_ack_fifo.sv | 93 +++++++++
 rtl/grant_ack_source.sv | 85 ++++++++
 tb/tb_grant_ack_source.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/grant_ack_pkg.sv
// Shared TileLink D-channel opcode constants and decode helper for the GrantAck source.
// Latency: n/a (constants and a pure combinational function).
// Backpressure: n/a.
package grant_ack_pkg;

    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;
    localparam logic [2:0] TL_GRANT           = 3'd4;
    localparam logic [2:0] TL_GRANT_DATA      = 3'd5;
    localparam logic [2:0] TL_RELEASE_ACK     = 3'd6;

    // Only Grant and GrantData transfer permissions and so need a GrantAck.
    function automatic logic is_grant(input logic [2:0] opcode);
        return (opcode == TL_GRANT) || (opcode == TL_GRANT_DATA);
    endfunction

endpackage

// File: rtl/grant_ack_fifo.sv
// Pending GrantAck queue: sink-id storage, wrapping pointers, occupancy count, sticky overflow.
// Latency: a push is visible at the head one cycle later.
// Backpressure: push with a full queue and no pop is dropped and sets overflow; push+pop when full reuses the freed slot.
//
// Ports:
//   clock, reset     clock and asynchronous active-low reset
//   push, push_dat   write request and sink id
//   pop              advance the head (ignored when empty)
//   count            occupancy 0..DEPTH
//   head_dat         entry at the read pointer
//   overflow         sticky drop indicator
module grant_ack_fifo #(
    parameter int DEPTH  = 4,   // power of two, >= 2
    parameter int SINK_W = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [SINK_W-1:0]          push_dat,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [SINK_W-1:0]          head_dat,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [SINK_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              empty;
    logic              do_push;
    logic              do_pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A pop frees a slot in the same cycle, so a full queue still accepts
    // a push that coincides with a pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign head_dat = mem[rd_ptr];

    // Storage is reset so the head reads zero out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (push & full & ~do_pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/grant_ack_source.sv
// TileLink E-channel GrantAck source: one GrantAck per completed Grant/GrantData on the D-channel response strobe.
// Latency: 1 cycle from last beat to io_e_valid (0 when GRANT_ACK_SOURCE_BYPASS_EN is defined and the queue is empty).
// Backpressure: io_e valid/ready; io_room throttles the D sink with a one-slot margin; acks beyond DEPTH are dropped and flagged.
//
// Optional feature macro: GRANT_ACK_SOURCE_BYPASS_EN (same-cycle ack when the queue is empty).
// Ports:
//   clock, reset                 clock and asynchronous active-low reset
//   io_resp_*                    D-channel response strobe (no ready; always taken)
//   io_e_valid/ready/bits_sink   E-channel GrantAck
//   io_room                      queue can absorb another message
//   io_count                     queue occupancy
//   io_overflow                  sticky: a GrantAck was dropped
module grant_ack_source
    import grant_ack_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int SINK_W = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       io_resp_valid,
    input  logic                       io_resp_bits_last,
    input  logic [2:0]                 io_resp_bits_opcode,
    input  logic [SINK_W-1:0]          io_resp_bits_sink,
    input  logic                       io_resp_bits_denied,
    input  logic                       io_e_ready,
    output logic                       io_e_valid,
    output logic [SINK_W-1:0]          io_e_bits_sink,
    output logic                       io_room,
    output logic [$clog2(DEPTH+1)-1:0] io_count,
    output logic                       io_overflow
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              acc;
    logic              q_push;
    logic              q_pop;
    logic [CNT_W-1:0]  q_count;
    logic [SINK_W-1:0] q_head;
    logic              q_empty;

    // A denied Grant still needs its GrantAck, so the flag plays no part here.
    logic unused_denied;
    assign unused_denied = io_resp_bits_denied;

    // Acknowledge once per message, on its final beat.
    assign acc     = io_resp_valid & io_resp_bits_last & is_grant(io_resp_bits_opcode);
    assign q_empty = (q_count == '0);

`ifdef GRANT_ACK_SOURCE_BYPASS_EN
    // Empty queue: present the incoming sink directly. If the E channel takes
    // it now nothing is stored; otherwise it is queued and re-presented from
    // the head next cycle with the same sink, keeping valid/data stable.
    assign io_e_valid     = ~q_empty | acc;
    assign io_e_bits_sink = q_empty ? io_resp_bits_sink : q_head;
    assign q_push         = acc & ~(q_empty & io_e_ready);
`else
    assign io_e_valid     = ~q_empty;
    assign io_e_bits_sink = q_head;
    assign q_push         = acc;
`endif

    // The queue ignores pop when empty, so ready alone is enough here.
    assign q_pop = io_e_ready;

    grant_ack_fifo #(
        .DEPTH  (DEPTH),
        .SINK_W (SINK_W)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (q_push),
        .push_dat (io_resp_bits_sink),
        .pop      (q_pop),
        .count    (q_count),
        .head_dat (q_head),
        .overflow (io_overflow)
    );

    // One slot of margin: a message can complete in the same cycle room falls.
    assign io_room  = (q_count < CNT_W'(DEPTH - 1));
    assign io_count = q_count;

endmodule

// File: tb/tb_grant_ack_source.sv
// Self-checking bench for grant_ack_source against a queue-based reference model.
// Latency: n/a.
// Backpressure: randomised io_e_ready plus directed stall/full/overflow scenarios.
module tb_grant_ack_source;

    localparam int DEPTH  = 4;
    localparam int SINK_W = 3;

    logic              clock;
    logic              reset;
    logic              io_resp_valid;
    logic              io_resp_bits_last;
    logic [2:0]        io_resp_bits_opcode;
    logic [SINK_W-1:0] io_resp_bits_sink;
    logic              io_resp_bits_denied;
    logic              io_e_ready;
    logic              io_e_valid;
    logic [SINK_W-1:0] io_e_bits_sink;
    logic              io_room;
    logic [2:0]        io_count;
    logic              io_overflow;

    grant_ack_source #(.DEPTH(DEPTH), .SINK_W(SINK_W)) dut (
        .clock               (clock),
        .reset               (reset),
        .io_resp_valid       (io_resp_valid),
        .io_resp_bits_last   (io_resp_bits_last),
        .io_resp_bits_opcode (io_resp_bits_opcode),
        .io_resp_bits_sink   (io_resp_bits_sink),
        .io_resp_bits_denied (io_resp_bits_denied),
        .io_e_ready          (io_e_ready),
        .io_e_valid          (io_e_valid),
        .io_e_bits_sink      (io_e_bits_sink),
        .io_room             (io_room),
        .io_count            (io_count),
        .io_overflow         (io_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pending acks in arrival order plus the sticky drop flag.
    int unsigned mq[$];
    bit          m_ovf;
    // Sinks actually acknowledged by the DUT, for order checks.
    int unsigned acked[$];

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input bit l, input int unsigned op,
                         input int unsigned s, input bit d, input bit r);
        io_resp_valid       = v;
        io_resp_bits_last   = l;
        io_resp_bits_opcode = op[2:0];
        io_resp_bits_sink   = s[SINK_W-1:0];
        io_resp_bits_denied = d;
        io_e_ready          = r;
    endtask

    // One clock cycle: check outputs mid-cycle, then advance the model across the edge.
    task automatic step(input string tag);
        bit          acc;
        bit          byp;
        bit          exp_vld;
        int unsigned exp_sink;
        int unsigned sz;
        @(negedge clock);
        acc = io_resp_valid && io_resp_bits_last &&
              (io_resp_bits_opcode == 3'd4 || io_resp_bits_opcode == 3'd5);
        sz  = mq.size();
        byp = 1'b0;
`ifdef GRANT_ACK_SOURCE_BYPASS_EN
        if (sz == 0 && acc) byp = 1'b1;
`endif
        if (byp) begin
            exp_vld  = 1'b1;
            exp_sink = io_resp_bits_sink;
        end else begin
            exp_vld  = (sz != 0);
            exp_sink = (sz != 0) ? mq[0] : 0;
        end
        chk({tag, "_vld"},   io_e_valid, exp_vld);
        if (exp_vld) chk({tag, "_sink"}, io_e_bits_sink, exp_sink);
        chk({tag, "_count"}, io_count, sz);
        chk({tag, "_room"},  io_room, (sz < DEPTH - 1) ? 1 : 0);
        chk({tag, "_ovf"},   io_overflow, m_ovf);
        if (io_e_valid && io_e_ready) acked.push_back(io_e_bits_sink);
        if (!(byp && io_e_ready)) begin
            if (exp_vld && io_e_ready && sz != 0) void'(mq.pop_front());
            if (acc) begin
                if (mq.size() < DEPTH) mq.push_back(io_resp_bits_sink);
                else                   m_ovf = 1'b1;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_steps(input int n, input bit r, input string tag);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, r);
            step(tag);
        end
    endtask

    // Asynchronous assert mid-cycle, release on a falling edge.
    task automatic async_reset(input string tag);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk({tag, "_rst_vld"},   io_e_valid, 0);
        chk({tag, "_rst_count"}, io_count, 0);
        chk({tag, "_rst_sink"},  io_e_bits_sink, 0);
        chk({tag, "_rst_room"},  io_room, 1);
        chk({tag, "_rst_ovf"},   io_overflow, 0);
        mq.delete();
        m_ovf = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    int unsigned ops[5] = '{0, 1, 4, 5, 6};

    initial begin
        mq.delete();
        m_ovf = 1'b0;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("por_vld",   io_e_valid, 0);
        chk("por_count", io_count, 0);
        chk("por_sink",  io_e_bits_sink, 0);
        chk("por_room",  io_room, 1);
        chk("por_ovf",   io_overflow, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Single GrantData: three non-final beats, then the final one.
        acked.delete();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 5, 3, 0, 1);
            step("gd_beat");
        end
        drive(1, 1, 5, 3, 0, 1);
        step("gd_last");
        idle_steps(3, 1, "gd_idle");
        chk("gd_acks", acked.size(), 1);
        if (acked.size() == 1) chk("gd_ack_sink", acked[0], 3);

        // Non-acking responses.
        acked.delete();
        drive(1, 1, 1, 2, 0, 1); step("aad");
        drive(1, 1, 6, 4, 0, 1); step("rack");
        drive(1, 0, 4, 1, 0, 1); step("grant_notlast");
        drive(1, 1, 0, 7, 0, 1); step("aack");
        idle_steps(2, 1, "noack_idle");
        chk("noack_acks", acked.size(), 0);

        // Denied Grant held against a stalled E channel.
        acked.delete();
        drive(1, 1, 4, 5, 1, 0);
        step("den_in");
        idle_steps(10, 0, "den_stall");
        chk("den_stall_acks", acked.size(), 0);
        idle_steps(3, 1, "den_rel");
        chk("den_acks", acked.size(), 1);
        if (acked.size() == 1) chk("den_ack_sink", acked[0], 5);

        // Fill to DEPTH, then overflow, then drain in order.
        acked.delete();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 1, 4, i, 0, 0);
            step("fill");
        end
        chk("fill_room", io_room, 0);
        chk("fill_count", io_count, 4);
        drive(1, 1, 4, 7, 0, 0);
        step("ovf_in");
        chk("ovf_set", io_overflow, 1);
        idle_steps(6, 1, "drain");
        chk("drain_n", acked.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < acked.size()) chk("drain_order", acked[i], i);
        chk("ovf_sticky", io_overflow, 1);

        // Full queue with simultaneous dequeue and enqueue.
        async_reset("pre_full");
        acked.delete();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 1, 5, i + 1, 0, 0);
            step("full_fill");
        end
        drive(1, 1, 4, 6, 0, 1);
        step("full_swap");
        chk("full_swap_count", io_count, 4);
        chk("full_swap_ovf", io_overflow, 0);
        idle_steps(6, 1, "full_drain");
        chk("full_n", acked.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < acked.size()) chk("full_order", acked[i], (i < 4) ? i + 1 : 6);

        // Reset with two entries pending.
        acked.delete();
        drive(1, 1, 4, 2, 0, 0); step("mr_a");
        drive(1, 1, 4, 3, 0, 0); step("mr_b");
        chk("mr_count", io_count, 2);
        async_reset("mr");
        idle_steps(4, 1, "mr_after");
        chk("mr_stale", acked.size(), 0);

        // Randomised traffic with varying E-channel pressure.
        begin
            int unsigned bias;
            bias = 50;
            for (int c = 0; c < 3000; c++) begin
                if (c % 200 == 0) bias = $urandom_range(10, 95);
                if ($urandom_range(0, 599) == 0) async_reset("rnd");
                drive($urandom_range(0, 99) < 60,
                      $urandom_range(0, 3) != 0,
                      ops[$urandom_range(0, 4)],
                      $urandom_range(0, (1 << SINK_W) - 1),
                      $urandom_range(0, 1),
                      $urandom_range(0, 99) < bias);
                step("rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
